// File: rtl/pipo_arb_pkg.sv
// Shared constants and types for the round-robin PIPO arbiter.
// Default sizes, FSM encoding and the request-wide zero word.
package pipo_arb_pkg;

  localparam int WIDTH_D = 4;
  localparam int NREQ_D  = 4;
  localparam int CNTW_D  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  localparam logic [NREQ_D-1:0] REQ_ZERO = '0;

endpackage

// File: rtl/pipo_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Rotates elig past last, takes the lowest set bit, rotates back.
import pipo_arb_pkg::*;

module rr_pick #(
  parameter int NREQ = NREQ_D,
  parameter int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [LW-1:0]   last,
  output logic            any,
  output logic [LW-1:0]   winner,
  output logic [NREQ-1:0] onehot
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [LW-1:0]     off;
  logic [LW:0]       sum;

  assign dbl = {elig, elig};
  assign rot = dbl[({1'b0, last} + 1'b1) +: NREQ];
  assign any = |rot;

  // lowest set bit of the rotated vector is the next in turn
  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = LW'(k);
    end
  end

  // map the rotated offset back to a requester index
  always_comb begin
    sum = {1'b0, last} + {1'b0, off} + (LW+1)'(1);
    if (sum >= (LW+1)'(NREQ)) sum = sum - (LW+1)'(NREQ);
    winner = sum[LW-1:0];
    onehot = '0;
    if (any) onehot[winner] = 1'b1;
  end

endmodule

// File: rtl/pipo_rr_arbiter.sv
// Round-robin sharing of one PIPO holding register.
// Winner's word is loaded and offered with valid/ready.
import pipo_arb_pkg::*;

module pipo_rr_arbiter #(
  parameter int WIDTH = WIDTH_D,
  parameter int NREQ  = NREQ_D,
  parameter int CNTW  = CNTW_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] pi_bus,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      po,
  output logic                  po_valid,
  input  logic                  po_ready,
  output logic                  busy,
  output logic [CNTW-1:0]       xfer_cnt
);

  localparam int LW = $clog2(NREQ);

  state_t          state, state_n;
  logic [LW-1:0]   last, winner;
  logic [NREQ-1:0] elig, onehot;
  logic            any, load, xfer;

  assign elig = req & ~gnt;

  rr_pick #(
    .NREQ(NREQ),
    .LW  (LW)
  ) u_pick (
    .elig  (elig),
    .last  (last),
    .any   (any),
    .winner(winner),
    .onehot(onehot)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // next state, load and handshake decode
  always_comb begin
    state_n = state;
    load    = 1'b0;
    xfer    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          load    = 1'b1;
          state_n = ST_FULL;
        end
      end
      ST_FULL: begin
        if (po_ready) begin
          xfer = 1'b1;
          if (any) load    = 1'b1;
          else     state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // outputs derived from the registered state
  always_comb begin
    po_valid = (state == ST_FULL);
    busy     = po_valid;
  end

  // grant pulse, data register, pointer and transfer counter
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= NREQ'(REQ_ZERO);
      po       <= '0;
      last     <= LW'(NREQ - 1);
      xfer_cnt <= '0;
    end else begin
      gnt <= load ? onehot : '0;
      if (load) begin
        po   <= pi_bus[int'(winner)*WIDTH +: WIDTH];
        last <= winner;
      end
      if (xfer) xfer_cnt <= xfer_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Bench for pipo_rr_arbiter: directed scenarios plus
// randomized traffic against a behavioural model.
module tb_pipo_rr_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int CNTW  = 8;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] pi_bus;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      po;
  logic                  po_valid;
  logic                  po_ready;
  logic                  busy;
  logic [CNTW-1:0]       xfer_cnt;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  int             m_last;
  int             m_gnt;
  bit             m_valid;
  logic [WIDTH-1:0] m_po;
  int             m_cnt;

  pipo_rr_arbiter #(
    .WIDTH(WIDTH),
    .NREQ (NREQ),
    .CNTW (CNTW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .pi_bus  (pi_bus),
    .gnt     (gnt),
    .po      (po),
    .po_valid(po_valid),
    .po_ready(po_ready),
    .busy    (busy),
    .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NREQ-1:0] m_gvec();
    logic [NREQ-1:0] v;
    v = '0;
    if (m_gnt >= 0) v[m_gnt] = 1'b1;
    return v;
  endfunction

  // one edge of the arbiter as described in plain terms
  task automatic model_step();
    int  w;
    bit  xf;
    if (rst) begin
      m_valid = 0;
      m_po    = '0;
      m_gnt   = -1;
      m_cnt   = 0;
      m_last  = NREQ - 1;
    end else begin
      xf = m_valid && po_ready;
      w  = -1;
      if (!m_valid || xf) begin
        for (int o = 1; o <= NREQ; o++) begin
          int i;
          i = (m_last + o) % NREQ;
          if (w < 0 && req[i] && i != m_gnt) w = i;
        end
      end
      if (xf) m_cnt = (m_cnt + 1) % (1 << CNTW);
      if (w >= 0) begin
        m_gnt   = w;
        m_last  = w;
        m_po    = pi_bus[w*WIDTH +: WIDTH];
        m_valid = 1;
      end else begin
        m_gnt = -1;
        if (xf) m_valid = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    po_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    po_ready = 1'b1;
    pi_bus = 16'h35FA;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || po !== 4'b0000 ||
          po_valid !== 1'b0 || xfer_cnt !== 8'd0) begin
        errors++;
        $display("FAIL reset: gnt=%b po=%b v=%b cnt=%0d want 0", gnt, po,
                 po_valid, xfer_cnt);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001 || po !== 4'b1010) begin
      errors++;
      $display("FAIL reset_first: gnt=%b po=%b want 0001 1010", gnt, po);
    end
  endtask

  task automatic test_single();
    do_reset();
    pi_bus = 16'h0A00;
    req = 4'b0100;
    po_ready = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0100 || po !== 4'b1010 || po_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: gnt=%b po=%b v=%b want 0100 1010 1",
               gnt, po, po_valid);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (po_valid !== 1'b0 || busy !== 1'b0 || xfer_cnt !== 8'd1 ||
        gnt !== 4'b0000 || po !== 4'b1010) begin
      errors++;
      $display("FAIL single_done: v=%b busy=%b cnt=%0d gnt=%b po=%b want 0 0 1 0000 1010",
               po_valid, busy, xfer_cnt, gnt, po);
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0]  eg [5];
    logic [WIDTH-1:0] ep [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    ep = '{4'b1010, 4'b1111, 4'b0101, 4'b0011, 4'b1010};
    do_reset();
    pi_bus = 16'h35FA;
    req = 4'b1111;
    po_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (gnt !== eg[c] || po !== ep[c] || po_valid !== 1'b1) begin
        errors++;
        $display("FAIL fairness[%0d]: gnt=%b po=%b want %b %b", c, gnt, po,
                 eg[c], ep[c]);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    pi_bus = 16'h35FA;
    req = 4'b0010;
    po_ready = 1'b0;
    tick();
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (po !== 4'b1111 || po_valid !== 1'b1 || gnt !== 4'b0000) begin
        errors++;
        $display("FAIL backpressure[%0d]: po=%b v=%b gnt=%b want 1111 1 0000",
                 c, po, po_valid, gnt);
      end
    end
    po_ready = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001 || po !== 4'b1010 || xfer_cnt !== 8'd1) begin
      errors++;
      $display("FAIL bp_release: gnt=%b po=%b cnt=%0d want 0001 1010 1",
               gnt, po, xfer_cnt);
    end
    req = '0;
    tick();
  endtask

  task automatic test_masking();
    logic [NREQ-1:0] prev;
    do_reset();
    req = 4'b1000;
    po_ready = 1'b1;
    prev = '0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (gnt !== ((c % 2 == 0) ? 4'b1000 : 4'b0000) ||
          (prev != 0 && gnt != 0)) begin
        errors++;
        $display("FAIL masking[%0d]: gnt=%b prev=%b", c, gnt, prev);
      end
      prev = gnt;
    end
    req = '0;
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    pi_bus = 16'h35FA;
    req = 4'b0100;
    po_ready = 1'b0;
    tick();
    rst = 1'b1;
    req = 4'b1111;
    tick();
    checks++;
    if (po_valid !== 1'b0 || gnt !== 4'b0000 || po !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset: v=%b gnt=%b po=%b want 0 0000 0000",
               po_valid, gnt, po);
    end
    rst = 1'b0;
    po_ready = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset_prio: gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b1111;
    po_ready = 1'b1;
    for (int c = 0; c < 256; c++) tick();
    checks++;
    if (xfer_cnt !== 8'd255) begin
      errors++;
      $display("FAIL wrap_255: cnt=%0d want 255", xfer_cnt);
    end
    tick();
    checks++;
    if (xfer_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0: cnt=%0d want 0", xfer_cnt);
    end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 59) == 0);
      req      = NREQ'($urandom);
      po_ready = ($urandom_range(0, 3) != 0);
      pi_bus   = (NREQ*WIDTH)'($urandom);
      tick();
      checks++;
      if (gnt !== m_gvec() || po !== m_po || po_valid !== m_valid ||
          busy !== m_valid || xfer_cnt !== CNTW'(m_cnt)) begin
        errors++;
        $display("FAIL random[%0d]: gnt=%b po=%h v=%b cnt=%0d want %b %h %b %0d",
                 c, gnt, po, po_valid, xfer_cnt, m_gvec(), m_po, m_valid, m_cnt);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    pi_bus = '0;
    po_ready = 1'b0;
    m_last = NREQ - 1;
    m_gnt = -1;
    m_valid = 0;
    m_po = '0;
    m_cnt = 0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_masking();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
